// File: rtl/led_out_pkg.sv
// Shared types and helpers for the LED blink output path.
//   led_state_e  : blink FSM encoding (IDLE, ON, OFF)
//   timer_width  : bit width of the phase timer for given ON/OFF lengths
package led_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } led_state_e;

  // Width that holds max(on_c, off_c); the timer only ever loads len-1.
  function automatic int unsigned timer_width(input int unsigned on_c,
                                              input int unsigned off_c);
    int unsigned m;
    m = (on_c > off_c) ? on_c : off_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter that times one ON or OFF phase.
//   clk, rst   : clock, synchronous active-low reset
//   load_i     : load load_val_i this cycle (phase entry)
//   load_val_i : phase length minus one
//   done_o     : registered, high while the count is zero
module blink_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;

  // Count down and stop at zero; done is kept equal to (cnt == 0) in a flop.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
    done_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/led_blink_out.sv
// Turns one-cycle event pulses into visible LED blinks (ON_CYCLES lit, then
// OFF_CYCLES dark). Events that arrive mid-blink are queued in a saturating
// pending counter; a lost event sets the sticky ovf flag.
//   clk, rst : clock, synchronous active-low reset
//   ev       : event pulse, each high cycle is one event
//   clr      : drop queued events and clear ovf (current blink finishes)
//   led      : LED drive (registered)
//   busy     : high whenever a blink is in progress (registered)
//   pend_cnt : queued events not yet started (registered)
//   ovf      : sticky lost-event flag (registered)
module led_blink_out
  import led_out_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned OFF_CYCLES = 4,
  parameter int unsigned PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev,
  input  logic              clr,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam int unsigned TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  led_state_e        state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              led_q, busy_q;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_done;
  logic              ev_eff;
  logic              queue_ev;

  blink_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state, timer load and pending-counter update.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    tmr_load = 1'b0;
    tmr_val  = ON_LOAD;
    queue_ev = 1'b0;
    // clr discards a same-cycle event
    ev_eff   = ev & ~clr;

    unique case (state_q)
      ST_IDLE: begin
        if (ev_eff) begin
          state_d  = ST_ON;
          tmr_load = 1'b1;
        end else if (pend_q != '0 && !clr) begin
          state_d  = ST_ON;
          tmr_load = 1'b1;
          pend_d   = pend_q - PEND_W'(1);
        end
      end
      ST_ON: begin
        queue_ev = ev_eff;
        if (tmr_done) begin
          state_d  = ST_OFF;
          tmr_load = 1'b1;
          tmr_val  = OFF_LOAD;
        end
      end
      ST_OFF: begin
        if (tmr_done) begin
          // An event at the very end of OFF starts the next blink directly.
          if (ev_eff) begin
            state_d  = ST_ON;
            tmr_load = 1'b1;
          end else if (pend_q != '0 && !clr) begin
            state_d  = ST_ON;
            tmr_load = 1'b1;
            pend_d   = pend_q - PEND_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          queue_ev = ev_eff;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Saturating queue; an event that does not fit is flagged.
    if (queue_ev) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end

    if (clr) begin
      pend_d = '0;
      ovf_d  = 1'b0;
    end
  end

  // State and output flops; led/busy are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= (state_d == ST_ON);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_led_blink_out.sv
// Self-checking bench for led_blink_out (ON=4, OFF=4, PEND_W=3).
// A phase-count reference model pushes the expected outputs for each driven
// cycle into a scoreboard queue; the entry is popped and compared once the
// DUT has produced that cycle. Directed timelines add absolute-cycle checks.
module tb_led_blink_out;

  localparam int unsigned ON_C  = 4;
  localparam int unsigned OFF_C = 4;
  localparam int unsigned PW    = 3;
  localparam int          PMAX  = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ev  = 1'b0;
  logic          clr = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pend_cnt;
  logic          ovf;

  led_blink_out #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ev       (ev),
    .clr      (clr),
    .led      (led),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  always #50 clk = ~clk;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [2:0] pend;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase 0 = idle, 1..ON = lit, ON+1..ON+OFF = dark.
  int m_phase = 0;
  int m_pend  = 0;
  bit m_ovf   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit e, input bit c, input bit r);
    bit evv;
    evv = e && !c;
    if (!r) begin
      m_phase = 0;
      m_pend  = 0;
      m_ovf   = 1'b0;
    end else begin
      if (m_phase == 0 || m_phase == int'(ON_C + OFF_C)) begin
        if (evv) begin
          m_phase = 1;
        end else if (m_pend > 0 && !c) begin
          m_phase = 1;
          m_pend--;
        end else begin
          m_phase = 0;
        end
      end else begin
        m_phase++;
        if (evv) begin
          if (m_pend == PMAX) m_ovf = 1'b1;
          else m_pend++;
        end
      end
      if (c) begin
        m_pend = 0;
        m_ovf  = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs (called at negedge), then compare after the edge.
  task automatic cycle(input bit e, input bit c, input bit r);
    exp_t x;
    ev  = e;
    clr = c;
    rst = r;
    model_step(e, c, r);
    x.led  = (m_phase >= 1 && m_phase <= int'(ON_C));
    x.busy = (m_phase != 0);
    x.pend = 3'(m_pend);
    x.ovf  = m_ovf;
    sb_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      x = sb_q.pop_front();
      check_val("sb_led",  32'(led),      32'(x.led));
      check_val("sb_busy", 32'(busy),     32'(x.busy));
      check_val("sb_pend", 32'(pend_cnt), 32'(x.pend));
      check_val("sb_ovf",  32'(ovf),      32'(x.ovf));
    end
  endtask

  initial begin
    logic led_prev;
    int   c;

    // 1. reset held, then released idle
    for (int t = 0; t < 4; t++) cycle(1'b0, 1'b0, 1'b0);
    check_val("rst_led",  32'(led),      32'd0);
    check_val("rst_busy", 32'(busy),     32'd0);
    check_val("rst_pend", 32'(pend_cnt), 32'd0);
    check_val("rst_ovf",  32'(ovf),      32'd0);
    for (int t = 0; t < 6; t++) cycle(1'b0, 1'b0, 1'b1);
    check_val("idle_busy", 32'(busy), 32'd0);

    // 2. single pulse at cycle 10: lit 11-14, dark 15-18, idle from 19
    for (int t = 0; t < 24; t++) begin
      cycle(t == 10, 1'b0, 1'b1);
      c = t + 1;
      check_val("t2_led",  32'(led),  32'(c >= 11 && c <= 14));
      check_val("t2_busy", 32'(busy), 32'(c >= 11 && c <= 18));
    end

    // 3. pulses at 10,12,13: rising edges 11,19,27; busy drops at 35
    led_prev = 1'b0;
    for (int t = 0; t < 40; t++) begin
      cycle(t == 10 || t == 12 || t == 13, 1'b0, 1'b1);
      c = t + 1;
      check_val("t3_rise", 32'(led && !led_prev),
                32'(c == 11 || c == 19 || c == 27));
      check_val("t3_busy", 32'(busy), 32'(c >= 11 && c <= 34));
      if (c == 14) check_val("t3_pend2", 32'(pend_cnt), 32'd2);
      led_prev = led;
    end

    // 4. ev held 12 cycles: saturation at max and sticky ovf
    for (int t = 0; t < 12; t++) cycle(1'b1, 1'b0, 1'b1);
    check_val("t4_pend_max", 32'(pend_cnt), 32'd7);
    check_val("t4_ovf",      32'(ovf),      32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    check_val("t4_ovf_sticky", 32'(ovf), 32'd1);
    for (int t = 0; t < 70; t++) cycle(1'b0, 1'b0, 1'b1);
    check_val("t4_drain_pend", 32'(pend_cnt), 32'd0);
    check_val("t4_drain_busy", 32'(busy),     32'd0);
    check_val("t4_ovf_kept",   32'(ovf),      32'd1);

    // 5. clr during the first ON phase drops the queue; blink 1 completes
    for (int t = 0; t < 26; t++) begin
      cycle(t == 10 || t == 12 || t == 13, t == 14, 1'b1);
      c = t + 1;
      if (c == 14) check_val("t5_pend_pre", 32'(pend_cnt), 32'd2);
      if (c == 15) begin
        check_val("t5_pend_clr", 32'(pend_cnt), 32'd0);
        check_val("t5_ovf_clr",  32'(ovf),      32'd0);
      end
      check_val("t5_busy", 32'(busy), 32'(c >= 11 && c <= 18));
    end

    // clr beats a same-cycle event from idle
    cycle(1'b1, 1'b1, 1'b1);
    check_val("clr_ev_idle", 32'(busy), 32'd0);

    // 6. reset during ON with two queued events
    for (int t = 0; t < 15; t++) begin
      cycle(t == 10 || t == 12 || t == 13, 1'b0, t != 14);
      c = t + 1;
      if (c == 14) check_val("t6_pend_pre", 32'(pend_cnt), 32'd2);
    end
    check_val("t6_led",  32'(led),      32'd0);
    check_val("t6_busy", 32'(busy),     32'd0);
    check_val("t6_pend", 32'(pend_cnt), 32'd0);
    for (int t = 0; t < 4; t++) cycle(1'b0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      cycle($urandom_range(2) == 0, $urandom_range(40) == 0,
            $urandom_range(150) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
